// File: rtl/lb_window_ctrl_pkg.sv
// Shared definitions for the line-buffer window sequencer: FSM encodings and kernel geometry.
package lb_window_ctrl_pkg;

  localparam int DEF_PIX_W = 8;
  localparam int KSIZE     = 5;
  localparam int KHALF     = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } lb_state_e;

endpackage

// File: rtl/lb_pos_cnt.sv
// Raster position counter. row/col give the position of the pixel being loaded this cycle;
// restart forces that pixel to (0,0) so an in-stream sof resynchronises the frame.
module lb_pos_cnt #(
  parameter int IMG_W = 320,
  parameter int IMG_H = 240,
  parameter int RW    = $clog2(IMG_H + 2),
  parameter int CW    = $clog2(IMG_W)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          restart,
  output logic [RW-1:0] row,
  output logic [CW-1:0] col,
  output logic          last_col
);

  logic [RW-1:0] row_q;
  logic [CW-1:0] col_q;

  assign row      = restart ? '0 : row_q;
  assign col      = restart ? '0 : col_q;
  assign last_col = (col == CW'(IMG_W - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_q <= '0;
      col_q <= '0;
    end else if (en) begin
      if (last_col) begin
        col_q <= '0;
        row_q <= row + 1'b1;
      end else begin
        col_q <= col + 1'b1;
        row_q <= row;
      end
    end
  end

endmodule

// File: rtl/lb_window_ctrl.sv
// Line-buffer sequencer for the 5x5 Canny kernel: handshake, load, position and window valids.
// Optional macro LB_FLUSH_EN adds a FLUSH state injecting 2*IMG_W zero pixels after the frame.
module lb_window_ctrl
  import lb_window_ctrl_pkg::*;
#(
  parameter int IMG_W = 320,
  parameter int IMG_H = 240,
  parameter int PIX_W = DEF_PIX_W,
  parameter int RW    = $clog2(IMG_H + 2),
  parameter int WR    = $clog2(IMG_H),
  parameter int CW    = $clog2(IMG_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_sof,
  input  logic [PIX_W-1:0] in_pixel,
  output logic             in_ready,
  input  logic             hold,
  output logic             lb_ld,
  output logic [PIX_W-1:0] lb_pixel,
  output logic             col_valid,
  output logic             win_valid,
  output logic [WR-1:0]    win_row,
  output logic [CW-1:0]    win_col,
  output logic             frame_done,
  output logic             err_sof,
  output lb_state_e        dbg_state
);

  lb_state_e state, state_nxt;

  logic          accept;
  logic          load;
  logic          restart;
  logic          inject;
  logic          last_ld;
  logic [RW-1:0] pos_row;
  logic [CW-1:0] pos_col;
  logic          pos_last_col;
  logic          run_last;

  // Stage 1 is the register feeding the line buffer; stage 2 lines up with its registered taps.
  logic             s1_ld, s1_colv, s1_winv, s1_last;
  logic [PIX_W-1:0] s1_pix;
  logic [WR-1:0]    s1_row;
  logic [CW-1:0]    s1_col;
  logic             s2_ld, s2_colv, s2_winv, s2_last;
  logic [WR-1:0]    s2_row;
  logic [CW-1:0]    s2_col;

  // Handshake: a pixel transfers on a cycle where in_valid and in_ready are both high;
  // in_ready never depends on in_valid, and upstream holds pixel/sof until the transfer.
  assign in_ready  = rst && ((state == ST_IDLE) || (state == ST_RUN)) && !hold;
  assign accept    = in_valid && in_ready;
  assign run_last  = pos_last_col && (pos_row == RW'(IMG_H - 1));
  assign dbg_state = state;

`ifdef LB_FLUSH_EN
  logic flush_last;
  assign flush_last = pos_last_col && (pos_row == RW'(IMG_H + 1));
`endif

  lb_pos_cnt #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .RW    (RW),
    .CW    (CW)
  ) u_pos_cnt (
    .clk      (clk),
    .rst      (rst),
    .en       (load),
    .restart  (restart),
    .row      (pos_row),
    .col      (pos_col),
    .last_col (pos_last_col)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    restart   = 1'b0;
    inject    = 1'b0;
    last_ld   = 1'b0;
    case (state)
      ST_IDLE: begin
        // Non-sof pixels are accepted here and dropped until a frame starts.
        if (accept && in_sof) begin
          load      = 1'b1;
          restart   = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (accept) begin
          load    = 1'b1;
          restart = in_sof;
          if (run_last && !in_sof) begin
`ifdef LB_FLUSH_EN
            state_nxt = ST_FLUSH;
`else
            state_nxt = ST_DONE;
            last_ld   = 1'b1;
`endif
          end
        end
      end
`ifdef LB_FLUSH_EN
      ST_FLUSH: begin
        if (!hold) begin
          load   = 1'b1;
          inject = 1'b1;
          if (flush_last) begin
            state_nxt = ST_DONE;
            last_ld   = 1'b1;
          end
        end
      end
`endif
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_ld   <= 1'b0;
      s1_colv <= 1'b0;
      s1_winv <= 1'b0;
      s1_last <= 1'b0;
      s1_pix  <= '0;
      s1_row  <= '0;
      s1_col  <= '0;
      s2_ld   <= 1'b0;
      s2_colv <= 1'b0;
      s2_winv <= 1'b0;
      s2_last <= 1'b0;
      s2_row  <= '0;
      s2_col  <= '0;
    end else if (!hold) begin
      s1_ld <= load;
      if (load) begin
        s1_pix  <= inject ? '0 : in_pixel;
        s1_colv <= (pos_row >= RW'(KSIZE - 1));
        s1_winv <= (pos_row >= RW'(KSIZE - 1)) && (pos_col >= CW'(KSIZE - 1));
        s1_last <= last_ld;
        s1_row  <= WR'(pos_row - RW'(KHALF));
        s1_col  <= CW'(pos_col - CW'(KHALF));
      end
      s2_ld   <= s1_ld;
      s2_colv <= s1_colv;
      s2_winv <= s1_winv;
      s2_last <= s1_last;
      s2_row  <= s1_row;
      s2_col  <= s1_col;
    end else begin
      // Stage 2 was presented once already; stage 1 waits for hold to drop.
      s2_ld <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_sof <= 1'b0;
    end else if ((state == ST_RUN && accept && in_sof) ||
                 (state == ST_FLUSH && in_valid && in_sof)) begin
      err_sof <= 1'b1;
    end
  end

  assign lb_ld      = s1_ld && !hold;
  assign lb_pixel   = s1_pix;
  assign col_valid  = s2_ld && s2_colv;
  assign win_valid  = s2_ld && s2_winv;
  assign frame_done = s2_ld && s2_last;
  assign win_row    = s2_row;
  assign win_col    = s2_col;

endmodule
